// File: rtl/zstd_rr_channel_arbiter.sv
// Round-robin arbiter that funnels N requesters into one registered valid/ready stage tagged with the source index.
// Define ZSTD_ARB_PACKET_LOCK_EN to hold the grant on one requester until its packet's last word has transferred.
module zstd_rr_channel_arbiter #(
    parameter int NumInputs = 4,
    parameter int Width     = 32,
    localparam int IdxWidth = $clog2(NumInputs)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NumInputs*Width-1:0] in_data_i,
    input  logic [NumInputs-1:0]       in_last_i,
    input  logic [NumInputs-1:0]       in_valid_i,
    output logic [NumInputs-1:0]       in_ready_o,
    output logic [Width-1:0]           out_data_o,
    output logic                       out_last_o,
    output logic [IdxWidth-1:0]        out_src_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumInputs - 1);
    localparam logic [IdxWidth:0]   NumWide = (IdxWidth + 1)'(NumInputs);

    logic                 full_q;
    logic [Width-1:0]     outData_q;
    logic                 outLast_q;
    logic [IdxWidth-1:0]  outSrc_q;
    logic [IdxWidth-1:0]  ptr_q;
    logic [IdxWidth-1:0]  ptr_d;

    logic [IdxWidth-1:0]  rrIdx;
    logic                 rrHit;
    logic [IdxWidth-1:0]  grantIdx;
    logic                 grantHit;
    logic [Width-1:0]     grantData;
    logic                 grantLast;
    logic [NumInputs-1:0] inReady;
    logic                 canAccept;
    logic                 transfer;

`ifdef ZSTD_ARB_PACKET_LOCK_EN
    typedef enum logic {
        IDLE,
        LOCKED
    } lockState_e;

    lockState_e          lockState_q;
    logic [IdxWidth-1:0] owner_q;
`endif

    // Offsets are walked high to low so the nearest valid requester at or after ptr is the last one written.
    always_comb begin
        logic [IdxWidth:0] pos;
        rrIdx = '0;
        rrHit = 1'b0;
        pos   = '0;
        for (int k = NumInputs - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_q} + (IdxWidth + 1)'(k);
            if (pos >= NumWide) begin
                pos = pos - NumWide;
            end
            if (in_valid_i[pos[IdxWidth-1:0]]) begin
                rrIdx = pos[IdxWidth-1:0];
                rrHit = 1'b1;
            end
        end
    end

`ifdef ZSTD_ARB_PACKET_LOCK_EN
    // While a packet is open the owner keeps the grant even if it momentarily drops valid.
    assign grantIdx = (lockState_q == LOCKED) ? owner_q : rrIdx;
    assign grantHit = (lockState_q == LOCKED) || rrHit;
`else
    assign grantIdx = rrIdx;
    assign grantHit = rrHit;
`endif

    assign canAccept = !full_q || out_ready_i;
    assign ptr_d     = (grantIdx == LastIdx) ? '0 : grantIdx + IdxWidth'(1);

    always_comb begin
        grantData = '0;
        grantLast = 1'b0;
        inReady   = '0;
        for (int i = 0; i < NumInputs; i++) begin
            if (grantIdx == IdxWidth'(i)) begin
                grantData  = in_data_i[i*Width +: Width];
                grantLast  = in_last_i[i];
                inReady[i] = grantHit && canAccept && !rst;
            end
        end
    end

    assign transfer = |(inReady & in_valid_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 1'b0;
            outData_q <= '0;
            outLast_q <= 1'b0;
            outSrc_q  <= '0;
            ptr_q     <= '0;
`ifdef ZSTD_ARB_PACKET_LOCK_EN
            lockState_q <= IDLE;
            owner_q     <= '0;
`endif
        end else begin
            if (transfer) begin
                full_q    <= 1'b1;
                outData_q <= grantData;
                outLast_q <= grantLast;
                outSrc_q  <= grantIdx;
            end else if (full_q && out_ready_i) begin
                full_q <= 1'b0;
            end
`ifdef ZSTD_ARB_PACKET_LOCK_EN
            // Rotation is frozen for the whole packet and resumes after the owner once its last word goes.
            if (transfer) begin
                case (lockState_q)
                    IDLE: begin
                        if (grantLast) begin
                            ptr_q <= ptr_d;
                        end else begin
                            lockState_q <= LOCKED;
                            owner_q     <= grantIdx;
                        end
                    end
                    LOCKED: begin
                        if (grantLast) begin
                            ptr_q       <= ptr_d;
                            lockState_q <= IDLE;
                        end
                    end
                    default: lockState_q <= IDLE;
                endcase
            end
`else
            if (transfer) begin
                ptr_q <= ptr_d;
            end
`endif
        end
    end

    assign in_ready_o  = inReady;
    assign out_data_o  = outData_q;
    assign out_last_o  = outLast_q;
    assign out_src_o   = outSrc_q;
    assign out_valid_o = full_q;

endmodule

// File: tb/tb_zstd_rr_channel_arbiter.sv
// Self-checking bench for zstd_rr_channel_arbiter: a rotating-priority reference model checked every cycle
// plus hand-computed pinned expectations for the directed scenarios.
module tb_zstd_rr_channel_arbiter;

    localparam int N = 4;
    localparam int W = 32;
`ifdef ZSTD_ARB_PACKET_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N*W-1:0] inData;
    logic [N-1:0]   inLast;
    logic [N-1:0]   inValid;
    logic [N-1:0]   inReady;
    logic [W-1:0]   outData;
    logic           outLast;
    logic [1:0]     outSrc;
    logic           outValid;
    logic           outReady;

    typedef struct {
        string       name;
        int          sel;
        int          arg;
        logic [31:0] exp;
    } pin_t;

    pin_t pinQ[$];
    int   pinRd = 0;
    int   popQ[$];

    int checkCount = 0;
    int failCount  = 0;

    int          stimCount = 0;
    bit          forceA5   = 1'b0;
    logic [31:0] expWord;
    int          popBase;
    int          expQ[$];

    bit          mFull   = 1'b0;
    logic [31:0] mData   = '0;
    logic        mLast   = 1'b0;
    int          mSrc    = 0;
    int          mPtr    = 0;
    bit          mLocked = 1'b0;
    int          mOwner  = 0;
    int          mPick;
    logic [N-1:0] mReady;
    bit          mCanAcc;
    logic [31:0] pinAct;

    zstd_rr_channel_arbiter #(
        .NumInputs(N),
        .Width(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data_i(inData),
        .in_last_i(inLast),
        .in_valid_i(inValid),
        .in_ready_o(inReady),
        .out_data_o(outData),
        .out_last_o(outLast),
        .out_src_o(outSrc),
        .out_valid_o(outValid),
        .out_ready_i(outReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    function automatic logic [31:0] laneWord(input int i);
        logic [N*W-1:0] t;
        t = inData >> (i * W);
        return t[W-1:0];
    endfunction

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Mid-cycle compare: DUT vs the rotating-priority model, then any pinned literals, then advance the model
    // with the inputs the DUT will see at the coming rising edge.
    always @(negedge clk) begin
        if (outValid && outReady) begin
            popQ.push_back(int'(outSrc));
        end

        mPick = -1;
        if (mLocked) begin
            mPick = mOwner;
        end else begin
            for (int s = 0; s < N; s++) begin
                if (mPick < 0 && inValid[(mPtr + s) % N]) begin
                    mPick = (mPtr + s) % N;
                end
            end
        end
        mCanAcc = !mFull || outReady;
        mReady  = '0;
        if (!rst && mPick >= 0 && mCanAcc) begin
            mReady[mPick] = 1'b1;
        end

        checkOutput("in_ready", 32'(inReady), 32'(mReady));
        checkOutput("out_valid", 32'(outValid), 32'(mFull));
        checkOutput("out_data", outData, mData);
        checkOutput("out_last", 32'(outLast), 32'(mLast));
        checkOutput("out_src", 32'(outSrc), 32'(mSrc));

        while (pinRd < pinQ.size()) begin
            case (pinQ[pinRd].sel)
                0:       pinAct = 32'(inReady);
                1:       pinAct = 32'(outValid);
                2:       pinAct = outData;
                3:       pinAct = 32'(outSrc);
                4:       pinAct = (pinQ[pinRd].arg < popQ.size()) ? 32'(popQ[pinQ[pinRd].arg]) : 32'hFFFF_FFFF;
                default: pinAct = 32'(popQ.size() - pinQ[pinRd].arg);
            endcase
            checkOutput(pinQ[pinRd].name, pinAct, pinQ[pinRd].exp);
            pinRd++;
        end

        if (rst) begin
            mFull   = 1'b0;
            mData   = '0;
            mLast   = 1'b0;
            mSrc    = 0;
            mPtr    = 0;
            mLocked = 1'b0;
            mOwner  = 0;
        end else if (mPick >= 0 && mCanAcc && inValid[mPick]) begin
            mFull = 1'b1;
            mData = laneWord(mPick);
            mLast = inLast[mPick];
            mSrc  = mPick;
            if (mLocked) begin
                if (inLast[mPick]) begin
                    mLocked = 1'b0;
                    mPtr    = (mOwner + 1) % N;
                end
            end else if (LockEn && !inLast[mPick]) begin
                mLocked = 1'b1;
                mOwner  = mPick;
            end else begin
                mPtr = (mPick + 1) % N;
            end
        end else if (mFull && outReady) begin
            mFull = 1'b0;
        end
    end

    task pin(input string name, input int sel, input int arg, input logic [31:0] exp);
        pin_t p;
        p.name = name;
        p.sel  = sel;
        p.arg  = arg;
        p.exp  = exp;
        pinQ.push_back(p);
    endtask

    task pinPops(input string name, input int base);
        pin($sformatf("%s count", name), 5, base, 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            pin($sformatf("%s pop%0d", name, i), 4, base + i, 32'(expQ[i]));
        end
    endtask

    task driveInputs(input logic rstV, input logic [N-1:0] validV, input logic [N-1:0] lastV, input logic readyV);
        stimCount++;
        rst      = rstV;
        inValid  = validV;
        inLast   = lastV;
        outReady = readyV;
        for (int i = 0; i < N; i++) begin
            inData[i*W +: W] = {stimCount[15:0], 8'(i), 8'h5A};
        end
        if (forceA5) begin
            inData[2*W +: W] = 32'h0000_00A5;
        end
    endtask

    task stepCycle;
        @(posedge clk);
        #1;
    endtask

    task applyStimulus(input logic rstV, input logic [N-1:0] validV, input logic [N-1:0] lastV, input logic readyV);
        driveInputs(rstV, validV, lastV, readyV);
        stepCycle();
    endtask

    initial begin
        int sent;
        int iter;

        driveInputs(1'b1, 4'b0000, 4'b1111, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b1);
        pin("reset out_valid", 1, 0, 32'h0);
        pin("reset out_data", 2, 0, 32'h0);
        pin("reset out_src", 3, 0, 32'h0);

        // Single requester 2 carrying 0xA5.
        forceA5 = 1'b1;
        driveInputs(1'b0, 4'b0100, 4'b1111, 1'b1);
        pin("single in_ready", 0, 0, 32'h4);
        stepCycle();
        forceA5 = 1'b0;
        driveInputs(1'b0, 4'b0000, 4'b1111, 1'b1);
        pin("single out_valid", 1, 0, 32'h1);
        pin("single out_data", 2, 0, 32'hA5);
        pin("single out_src", 3, 0, 32'h2);
        stepCycle();

        // Pointer sits at 3: requesters 3 and 0 wrap around.
        popBase = popQ.size();
        driveInputs(1'b0, 4'b1001, 4'b1111, 1'b1);
        pin("wrap in_ready", 0, 0, 32'h8);
        stepCycle();
        applyStimulus(1'b0, 4'b1001, 4'b1111, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1);
        expQ = '{3, 0};
        pinPops("wrap", popBase);

        // Reset while full (and mid-packet), then everyone valid from a fresh pointer.
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
        driveInputs(1'b1, 4'b1111, 4'b0000, 1'b0);
        pin("rst in_ready", 0, 0, 32'h0);
        pin("rst out_valid held", 1, 0, 32'h1);
        stepCycle();
        popBase = popQ.size();
        driveInputs(1'b0, 4'b1111, 4'b1111, 1'b1);
        pin("post-rst out_valid", 1, 0, 32'h0);
        pin("post-rst in_ready", 0, 0, 32'h1);
        stepCycle();
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
        end
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1);
        expQ = '{0, 1, 2, 3, 0, 1, 2, 3};
        pinPops("allvalid", popBase);

        // Backpressure: stage stays full and stable, then pops and refills in one cycle.
        driveInputs(1'b0, 4'b1111, 4'b1111, 1'b1);
        expWord = laneWord(0);
        stepCycle();
        for (int c = 0; c < 3; c++) begin
            driveInputs(1'b0, 4'b1111, 4'b1111, 1'b0);
            pin($sformatf("bp%0d in_ready", c), 0, 0, 32'h0);
            pin($sformatf("bp%0d out_valid", c), 1, 0, 32'h1);
            pin($sformatf("bp%0d out_data", c), 2, 0, expWord);
            stepCycle();
        end
        driveInputs(1'b0, 4'b1111, 4'b1111, 1'b1);
        pin("release in_ready", 0, 0, 32'h2);
        expWord = laneWord(1);
        stepCycle();
        driveInputs(1'b0, 4'b0000, 4'b1111, 1'b1);
        pin("refill out_valid", 1, 0, 32'h1);
        pin("refill out_src", 3, 0, 32'h1);
        pin("refill out_data", 2, 0, expWord);
        stepCycle();
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1);

        // Requester 1 sends a three-word packet while requester 2 stays valid.
        applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b1);
        popBase = popQ.size();
        sent = 0;
        iter = 0;
        while (sent < 3) begin
            if (iter >= 20) begin
                $display("[TB] FAIL packet_timeout: sent %0d words, required 3", sent);
                $fatal(1);
            end
            driveInputs(1'b0, 4'b0110, (sent == 2) ? 4'b0110 : 4'b0100, 1'b1);
            #1;
            if (inReady[1]) begin
                sent++;
            end
            stepCycle();
            iter++;
        end
        applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1);
`ifdef ZSTD_ARB_PACKET_LOCK_EN
        expQ = '{1, 1, 1, 2};
`else
        expQ = '{1, 2, 1, 2, 1, 2};
`endif
        pinPops("packet", popBase);
        stepCycle();
        stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/zstd_rr_channel_arbiter.md
Name: zstd_rr_channel_arbiter

Overview:
- N-input round-robin arbiter that shares one downstream valid/ready channel (typically the push side of a single-entry XLS FIFO wrapper) between several requesters in the zstd decoder.
- Selects one requester per transfer and registers the winning word into a one-entry output stage.
- Tags each output word with its source index so the consumer can demultiplex.
- Fairness is rotating priority: the most recently served requester becomes lowest priority.

Parameters:
- NumInputs, 4, number of requesters; legal range 2..16.
- Width, 32, data width per requester.
- IdxWidth, $clog2(NumInputs) (localparam), width of source index.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- in_data  input  NumInputs*Width  requester data. Requester i occupies bits [i*Width +: Width].
- in_last  input  NumInputs  end-of-packet flag per requester.
- in_valid  input  NumInputs  requester valid.
- in_ready  output  NumInputs  requester ready; one-hot or zero.
- out_data  output  Width  registered winning data.
- out_last  output  1  registered last flag of the winning word.
- out_src  output  IdxWidth  registered index of the winning requester.
- out_valid  output  1  output stage holds a word.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset values:
  - full=0, so out_valid=0.
  - out_data=0, out_last=0, out_src=0.
  - Priority pointer ptr=0.
  - Lock state IDLE.
  - in_ready=0 during the reset cycle.
- Output stage:
  - out_valid = full.
  - Downstream pop occurs when out_valid && out_ready.
- Accept condition: can_accept = !full || out_ready. The same-cycle pop-and-refill path is combinational; there are no bubbles at full throughput.
- Grant:
  - g = first index with in_valid set, searching ptr, ptr+1, ..., NumInputs-1, 0, ..., ptr-1 (modulo NumInputs).
  - in_ready[g] = can_accept. All other in_ready bits are 0.
  - If no in_valid is set, in_ready = 0.
  - in_ready never depends on in_valid of the same index, only on the search result. Requesters must not wait on ready before asserting valid.
- Transfer: occurs when in_valid[g] && in_ready[g]. Next cycle:
  - full=1.
  - out_data, out_last and out_src take requester g's values.
  - Latency is exactly 1 cycle from accept to out_valid.
- Pop without refill: full <= 0. out_data, out_last and out_src hold their values.
- No transfer and no pop: all registers hold.
- Pointer update on transfer: ptr <= (g == NumInputs-1) ? 0 : g+1. Pointer arithmetic is IdxWidth wide with explicit wrap, so non-power-of-two NumInputs is legal.
- Simultaneous pop and transfer in one cycle: the new word overwrites and full stays 1.
- A requester dropping valid before its transfer completes is legal. Arbitration is re-evaluated every cycle while no lock is held.
- Reset asserted mid-transfer or mid-packet: the pending word is discarded, ptr returns to 0, lock is cleared, and no output occurs in the following cycle.

Optional Feature:
- Macro: ZSTD_ARB_PACKET_LOCK_EN
- Defined:
  - Two-state FSM, IDLE and LOCKED(owner).
  - IDLE: grant per the round-robin rule. A transfer with in_last=0 moves to LOCKED with owner=g, and ptr is not updated.
  - LOCKED: grant is forced to owner regardless of other valids. in_ready[owner] = can_accept even if in_valid[owner]=0. Other in_ready bits are 0.
  - A transfer with in_last=1 in LOCKED sets ptr <= owner+1 (wrapped) and returns to IDLE.
  - A transfer with in_last=1 in IDLE updates ptr normally and stays IDLE.
  - Packets are never interleaved on the output.
- Undefined:
  - No FSM; in_last is only carried through to out_last.
  - Arbitration is per word, so packets from different requesters may interleave.

Test Plan:
- Single requester: NumInputs=4, in_valid=4'b0100, data 0xA5, out_ready=1 -> out_valid next cycle with out_data=0xA5 and out_src=2; ptr becomes 3.
- All requesters valid continuously, out_ready=1, 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 with one word per cycle after the first.
- Backpressure: full with out_ready=0 for 3 cycles -> in_ready=0 and out_data stable. Release out_ready -> pop and refill in the same cycle; out_valid stays 1.
- Wrap with ptr=3: in_valid=4'b1001 -> grant 3 first, then 0; out_src sequence 3,0.
- With ZSTD_ARB_PACKET_LOCK_EN: requester 1 sends a 3-word packet (last on word 3) while requester 2 is continuously valid -> out_src 1,1,1 then 2. Without the macro, same stimulus -> out_src alternates 1,2,1,2,1.
- Reset asserted while full and (lock variant) LOCKED -> next cycle out_valid=0 and in_ready=0. After release, with all valid, the first grant goes to index 0.
